pipe_skid_reg: RTL
==================

# pipe_skid_reg

Parametrised pipeline-stage register with a valid/ready handshake and a two-entry skid buffer. It is the general replacement for the fixed-width IF/ID-style stage registers, and sits between any two pipeline stages (IF→ID, ID→EX, …). It sustains one transfer per cycle with a fully registered `up_ready`, supports a synchronous flush that inserts a bubble carrying `FLUSH_VAL`, and counts downstream back-pressure cycles.

## Interface
- `DATA_W`, 64, payload width (e.g. {pc, inst}).
- `FLUSH_VAL`, `{DATA_W{1'b0}}`, payload driven for bubbles, after reset and after flush.
- `CNT_W`, 16, width of the back-pressure counter.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `flush` in 1: synchronous flush, highest priority.
- `up_valid` in 1: upstream payload valid.
- `up_ready` out 1: stage can accept; driven directly from a flop.
- `up_data` in `DATA_W`: upstream payload.
- `dn_valid` out 1: payload valid to downstream.
- `dn_ready` in 1: downstream accepts; low means stall.
- `dn_data` out `DATA_W`: payload to downstream, taken from the main register.
- `occupancy` out 2: entry count, 0 to 2.
- `stall_cnt` out `CNT_W`: saturating count of cycles with `dn_valid & !dn_ready`.

## Operation
- Transfers: `up_xfer = up_valid & up_ready`; `dn_xfer = dn_valid & dn_ready`.
- Storage: `main` register (drives `dn_data`) and `skid` register.
- State machine:
  - `EMPTY` (occ 0):
    - `up_xfer` → `BUSY`, main ← up_data.
  - `BUSY` (occ 1):
    - `up_xfer & dn_xfer` → `BUSY`, main ← up_data.
    - `up_xfer` only → `FULL`, skid ← up_data.
    - `dn_xfer` only → `EMPTY`, main ← FLUSH_VAL.
    - neither → hold.
  - `FULL` (occ 2):
    - `dn_xfer` → `BUSY`, main ← skid, skid ← FLUSH_VAL.
    - otherwise hold. `up_ready` is 0 here, so no accept occurs.
- Derived outputs:
  - `dn_valid` = state != `EMPTY`.
  - `occupancy` = state encoding count.
  - `up_ready` next = (next_state != `FULL`) & !flush-induced hold. `up_ready` is 1 in the cycle after a flush.
- Flush:
  - Forces `EMPTY`; main and skid ← FLUSH_VAL.
  - Any `up_xfer` in the flush cycle is discarded.
  - `dn_valid`/`dn_data` are registered and are not masked in the flush cycle. Whether that cycle's handshake counts is the downstream stage's decision; the stage simply empties.
- Ordering: payloads leave in the order accepted. No duplication, no loss except on flush.
- `stall_cnt`:
  - Increments when `dn_valid & !dn_ready`.
  - Saturates at all-ones.
  - Unaffected by flush; cleared only by reset.

## Timing
- Latency is 1 cycle: data accepted at edge N appears on `dn_data` with `dn_valid` after edge N.
- Throughput is 1 per cycle while `dn_ready` is high.
- `up_ready` drops in the cycle after the transfer that fills the skid, so one extra payload is absorbed after `dn_ready` falls.
- Reset values (asynchronous):
  - state `EMPTY`, `dn_valid` 0, `dn_data` FLUSH_VAL, skid FLUSH_VAL.
  - `up_ready` 0, `occupancy` 0, `stall_cnt` 0.
- First clock edge with `rst_n` high sets `up_ready` 1. No transfer is possible in the first cycle after reset release.
- Reset asserted mid-operation: all contents are discarded immediately, without waiting for a clock edge.
- Simultaneous events:
  - Flush beats reset-less transitions.
  - In `BUSY`, a simultaneous up and down transfer keeps occupancy at 1.
  - In `FULL`, `dn_xfer` never coincides with an accept.

## Structure
- Shared package `pipe_pkg` holds:
  - State typedef `pipe_state_t`: `ST_EMPTY`=2'd0, `ST_BUSY`=2'd1, `ST_FULL`=2'd2.
  - Default `PIPE_NOP` constant used as FLUSH_VAL by instruction-carrying stages.
- Natural sub-module: `sat_counter` (parameter `W`; `inc` and `cnt` ports; async active-low reset), used for `stall_cnt`.
- Everything else lives in a single always_ff plus next-state logic.

## Test plan
- Reset, then stream 0x1…0x8 with `dn_ready`=1:
  - `up_ready` is 0 in cycle 1 and 1 from cycle 2.
  - `dn_data` shows 0x1…0x8 one cycle after each accept, with no gaps.
  - `occupancy` stays ≤ 1.
- Back-pressure: stream 0xA, 0xB, 0xC with `dn_ready`=0 from after the 0xA accept:
  - 0xB lands in skid and `occupancy`=2.
  - `up_ready`=0 and 0xC is held upstream.
  - Raise `dn_ready`: output order is 0xA, 0xB, 0xC.
  - `stall_cnt` equals the number of stalled cycles.
- Flush while `FULL`:
  - Next cycle `dn_valid`=0, `dn_data`=FLUSH_VAL, `occupancy`=0, `up_ready`=1.
  - Flushed payloads never appear.
- Flush coincident with `up_valid`=1 (payload 0x55): 0x55 is discarded and the stage is `EMPTY`.
- Assert `rst_n`=0 asynchronously mid-stream, between edges: outputs take reset values immediately. After release, the stream resumes cleanly.
- Hold `dn_valid` with `dn_ready`=0 for more than 2^CNT_W cycles (`CNT_W`=4): `stall_cnt` saturates at 0xF.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for pipeline stage registers.
//   pipe_state_t : occupancy-coded state of a skid stage (value equals entry count).
//   PIPE_NOP     : canonical bubble payload for stages that carry a 32-bit instruction.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_t;

  // addi x0, x0, 0
  localparam logic [31:0] PIPE_NOP = 32'h0000_0013;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones.
//   clk   : clock
//   rst_n : asynchronous active-low reset, clears the count
//   inc   : count enable for this cycle
//   cnt   : current count
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: pipeline stage register with valid/ready handshake and a two-entry
// skid buffer. up_ready comes straight from a flop, so one extra payload is absorbed
// into the skid register after downstream stalls.
//   clk, rst_n          : clock, asynchronous active-low reset
//   flush               : synchronous flush, empties the stage and drops any accept
//   up_valid/up_ready   : upstream handshake, up_data payload in
//   dn_valid/dn_ready   : downstream handshake, dn_data payload out (main register)
//   occupancy           : entries held, 0..2
//   stall_cnt           : saturating count of cycles with dn_valid & !dn_ready
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W    = 64,
  parameter logic [DATA_W-1:0] FLUSH_VAL = {DATA_W{1'b0}},
  parameter int unsigned       CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [DATA_W-1:0] up_data,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic [DATA_W-1:0] dn_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  pipe_state_t       state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              up_ready_q, up_ready_d;
  logic              up_xfer, dn_xfer;

  assign dn_valid = (state_q != ST_EMPTY);
  assign up_xfer  = up_valid & up_ready_q;
  assign dn_xfer  = dn_valid & dn_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = FLUSH_VAL;
      skid_d  = FLUSH_VAL;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (up_xfer) begin
            state_d = ST_BUSY;
            main_d  = up_data;
          end
        end
        ST_BUSY: begin
          if (up_xfer && dn_xfer) begin
            main_d = up_data;
          end else if (up_xfer) begin
            state_d = ST_FULL;
            skid_d  = up_data;
          end else if (dn_xfer) begin
            state_d = ST_EMPTY;
            main_d  = FLUSH_VAL;
          end
        end
        ST_FULL: begin
          // up_ready is low in FULL, so no accept can coincide with this drain.
          if (dn_xfer) begin
            state_d = ST_BUSY;
            main_d  = skid_q;
            skid_d  = FLUSH_VAL;
          end
        end
        default: begin
          // Unreachable encoding: recover to a clean empty stage.
          state_d = ST_EMPTY;
          main_d  = FLUSH_VAL;
          skid_d  = FLUSH_VAL;
        end
      endcase
    end
    // Flush always lands in EMPTY, so ready is high in the cycle after a flush.
    up_ready_d = (state_d != ST_FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      main_q     <= FLUSH_VAL;
      skid_q     <= FLUSH_VAL;
      up_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      up_ready_q <= up_ready_d;
    end
  end

  assign up_ready  = up_ready_q;
  assign dn_data   = main_q;
  assign occupancy = state_q;

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (dn_valid & ~dn_ready),
    .cnt   (stall_cnt)
  );

endmodule
